// File: rtl/vga_pattern_tx_if.sv
// Video link bundle between the pattern source and whatever samples it (board GPIOs, capture path).
// There is no backpressure: the sink samples every output on every clock, frame_start marks pixel (0,0).
interface vga_pattern_tx_if;
   logic        hsync;
   logic        vsync;
   logic [2:0]  rgb;
   logic        visible;
   logic        frame_start;
   logic [15:0] frame_cnt;

   modport master (
      output hsync, vsync, rgb, visible, frame_start, frame_cnt
   );

   modport slave (
      input hsync, vsync, rgb, visible, frame_start, frame_cnt
   );
endinterface

// File: rtl/vga_pattern_tx.sv
// SVGA-style sync and 3-bit RGB test-pattern source: colour bars, checkerboard, solid colour, bouncing box.
// All video outputs are registered with one clock of latency from the h/v counters.
module vga_pattern_tx #(
   parameter int   H_VISIBLE = 800,
   parameter int   H_FRONT   = 40,
   parameter int   H_SYNC    = 128,
   parameter int   H_BACK    = 88,
   parameter int   V_VISIBLE = 600,
   parameter int   V_FRONT   = 1,
   parameter int   V_SYNC    = 4,
   parameter int   V_BACK    = 23,
   parameter logic HS_POL    = 1'b1,
   parameter logic VS_POL    = 1'b1,
   parameter int   BOX       = 64,
   parameter int   STEP      = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [1:0]          mode,
   input  logic [2:0]          solid_rgb,
   vga_pattern_tx_if.master    vid,
   output logic [0:0]          dbg_state
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int BAR_W   = H_VISIBLE / 8;
   localparam int BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [10:0] H_VIS_C  = 11'(H_VISIBLE);
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0]  V_VIS_C  = 10'(V_VISIBLE);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   localparam logic [BAR_CW-1:0]  BAR_LAST = BAR_CW'(BAR_W - 1);
   localparam logic signed [12:0] STEP_S   = 13'(STEP);
   localparam logic signed [12:0] BX_MAX_S = 13'(H_VISIBLE - BOX);
   localparam logic signed [11:0] BY_MAX_S = 12'(V_VISIBLE - BOX);
   localparam logic [10:0]        BX_MAX   = 11'(H_VISIBLE - BOX);
   localparam logic [9:0]         BY_MAX   = 10'(V_VISIBLE - BOX);
   localparam logic [11:0]        BOX_H    = 12'(BOX);
   localparam logic [10:0]        BOX_V    = 11'(BOX);

   // IDLE covers the clock on which enable is first seen high: counters sit at 0 and outputs stay idle.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        state;
   logic [10:0]       h_cnt;
   logic [9:0]        v_cnt;
   logic [2:0]        bar_idx;
   logic [BAR_CW-1:0] bar_sub;
   logic [1:0]        mode_q;
   logic [2:0]        solid_q;
   logic [10:0]       box_x;
   logic [9:0]        box_y;
   logic              dx_neg;
   logic              dy_neg;

   logic              running;
   logic              at_origin;
   logic              boundary;
   logic signed [12:0] box_x_sum;
   logic signed [11:0] box_y_sum;
   logic [10:0]       box_x_nxt;
   logic [9:0]        box_y_nxt;
   logic              dx_neg_nxt;
   logic              dy_neg_nxt;
   logic [1:0]        mode_eff;
   logic [2:0]        solid_eff;
   logic [10:0]       bx_eff;
   logic [9:0]        by_eff;
   logic              in_box;
   logic              pix_vis;
   logic [2:0]        pix_rgb;
   logic              hs_act;
   logic              vs_act;

   logic              hsync_q;
   logic              vsync_q;
   logic [2:0]        rgb_q;
   logic              visible_q;
   logic              frame_start_q;
   logic [15:0]       frame_cnt_q;

   assign running   = (state == ST_RUN) && enable;
   assign at_origin = (h_cnt == 11'd0) && (v_cnt == 10'd0);
   assign boundary  = running && at_origin;
   assign dbg_state = state;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= enable ? ST_RUN : ST_IDLE;
      end
   end

   // bar_idx/bar_sub track h_cnt / BAR_W incrementally so no divider is needed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         bar_idx <= '0;
         bar_sub <= '0;
      end else if (!running) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         bar_idx <= '0;
         bar_sub <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt   <= '0;
         bar_idx <= '0;
         bar_sub <= '0;
         v_cnt   <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 11'd1;
         if (bar_sub == BAR_LAST) begin
            bar_sub <= '0;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_sub <= bar_sub + BAR_CW'(1);
         end
      end
   end

   always_comb begin
      box_x_sum  = $signed({2'b00, box_x}) + (dx_neg ? -STEP_S : STEP_S);
      box_x_nxt  = box_x_sum[10:0];
      dx_neg_nxt = dx_neg;
      if (box_x_sum > BX_MAX_S) begin
         box_x_nxt  = BX_MAX;
         dx_neg_nxt = ~dx_neg;
      end else if (box_x_sum < 13'sd0) begin
         box_x_nxt  = '0;
         dx_neg_nxt = ~dx_neg;
      end

      box_y_sum  = $signed({2'b00, box_y}) + (dy_neg ? -STEP_S[11:0] : STEP_S[11:0]);
      box_y_nxt  = box_y_sum[9:0];
      dy_neg_nxt = dy_neg;
      if (box_y_sum > BY_MAX_S) begin
         box_y_nxt  = BY_MAX;
         dy_neg_nxt = ~dy_neg;
      end else if (box_y_sum < 12'sd0) begin
         box_y_nxt  = '0;
         dy_neg_nxt = ~dy_neg;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_q  <= '0;
         solid_q <= '0;
         box_x   <= '0;
         box_y   <= '0;
         dx_neg  <= 1'b0;
         dy_neg  <= 1'b0;
      end else if (boundary) begin
         mode_q  <= mode;
         solid_q <= solid_rgb;
         box_x   <= box_x_nxt;
         box_y   <= box_y_nxt;
         dx_neg  <= dx_neg_nxt;
         dy_neg  <= dy_neg_nxt;
      end
   end

   // Pixel (0,0) is rendered on the same clock the frame settings are latched, so bypass the registers there.
   always_comb begin
      mode_eff  = at_origin ? mode      : mode_q;
      solid_eff = at_origin ? solid_rgb : solid_q;
      bx_eff    = at_origin ? box_x_nxt : box_x;
      by_eff    = at_origin ? box_y_nxt : box_y;

      in_box  = (h_cnt >= bx_eff) && ({1'b0, h_cnt} < ({1'b0, bx_eff} + BOX_H)) &&
                (v_cnt >= by_eff) && ({1'b0, v_cnt} < ({1'b0, by_eff} + BOX_V));
      pix_vis = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
      hs_act  = (h_cnt >= HS_START) && (h_cnt < HS_END);
      vs_act  = (v_cnt >= VS_START) && (v_cnt < VS_END);

      case (mode_eff)
         2'd0:    pix_rgb = 3'd7 - bar_idx;
         2'd1:    pix_rgb = {3{h_cnt[5] ^ v_cnt[5]}};
         2'd2:    pix_rgb = solid_eff;
         default: pix_rgb = in_box ? 3'b111 : 3'b000;
      endcase
      if (!pix_vis) begin
         pix_rgb = 3'b000;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         rgb_q         <= '0;
         visible_q     <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else if (!running) begin
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         rgb_q         <= '0;
         visible_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= hs_act ? HS_POL : ~HS_POL;
         vsync_q       <= vs_act ? VS_POL : ~VS_POL;
         rgb_q         <= pix_rgb;
         visible_q     <= pix_vis;
         frame_start_q <= at_origin;
         if (at_origin) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   assign vid.hsync       = hsync_q;
   assign vid.vsync       = vsync_q;
   assign vid.rgb         = rgb_q;
   assign vid.visible     = visible_q;
   assign vid.frame_start = frame_start_q;
   assign vid.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_tx.sv
// Bench for vga_pattern_tx on a reduced raster: cycle-by-cycle reference scoreboard plus
// directed timing, pattern, mode-latch, bouncing-box, reset and enable checks.
module tb_vga_pattern_tx;

   localparam int HV = 64, HF = 2, HS = 4, HB = 2;
   localparam int VV = 40, VF = 1, VS = 2, VB = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int BOX = 16, STEP = 8;
   localparam logic HS_POL = 1'b1, VS_POL = 1'b1;

   // clock / reset
   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic       enable    = 1'b0;
   logic [1:0] mode      = 2'd0;
   logic [2:0] solid_rgb = 3'd0;
   logic [0:0] dbg_state;

   always #5 clock = ~clock;

   vga_pattern_tx_if vid();

   vga_pattern_tx #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HS_POL(HS_POL), .VS_POL(VS_POL), .BOX(BOX), .STEP(STEP)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode),
      .solid_rgb(solid_rgb), .vid(vid), .dbg_state(dbg_state)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // box position after n frame-boundary updates along one axis with limit lim
   function automatic int box_pos(input int n, input int lim);
      int p, d, np;
      p = 0;
      d = STEP;
      for (int i = 0; i < n; i++) begin
         np = p + d;
         if (np > lim) begin
            p = lim;
            d = -d;
         end else if (np < 0) begin
            p = 0;
            d = -d;
         end else begin
            p = np;
         end
      end
      return p;
   endfunction

   function automatic logic [22:0] idle_word(input int fc);
      logic [15:0] f;
      f = fc[15:0];
      return {~HS_POL, ~VS_POL, 3'b000, 1'b0, 1'b0, f};
   endfunction

   // scoreboard: reference model pushes the expected output word on every active edge
   logic [22:0] exp_q[$];
   logic [22:0] sb_exp;
   int          mh, mv, m_nb, m_fc, m_bx, m_by;
   logic        m_en, m_run, m_vis, m_hs, m_vs, m_fs;
   logic [1:0]  m_mode;
   logic [2:0]  m_solid, m_rgb;

   task automatic m_clear();
      mh = 0; mv = 0; m_nb = 0; m_fc = 0; m_en = 1'b0;
      m_mode = 2'd0; m_solid = 3'd0;
   endtask

   initial begin
      m_clear();
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            m_clear();
            exp_q.delete();
            exp_q.push_back(idle_word(0));
         end else begin
            m_run = enable && m_en;
            m_en  = enable;
            if (!m_run) begin
               mh = 0;
               mv = 0;
               exp_q.push_back(idle_word(m_fc));
            end else begin
               m_fs = (mh == 0) && (mv == 0);
               if (m_fs) begin
                  m_mode  = mode;
                  m_solid = solid_rgb;
                  m_nb++;
                  m_fc = (m_fc + 1) % 65536;
               end
               m_bx  = box_pos(m_nb, HV - BOX);
               m_by  = box_pos(m_nb, VV - BOX);
               m_vis = (mh < HV) && (mv < VV);
               case (m_mode)
                  2'd0:    m_rgb = 3'(7 - mh / (HV / 8));
                  2'd1:    m_rgb = (((mh >> 5) ^ (mv >> 5)) & 1) != 0 ? 3'b111 : 3'b000;
                  2'd2:    m_rgb = m_solid;
                  default: m_rgb = (mh >= m_bx && mh < m_bx + BOX && mv >= m_by && mv < m_by + BOX) ? 3'b111 : 3'b000;
               endcase
               if (!m_vis) m_rgb = 3'b000;
               m_hs = (mh >= HV + HF && mh < HV + HF + HS) ? HS_POL : ~HS_POL;
               m_vs = (mv >= VV + VF && mv < VV + VF + VS) ? VS_POL : ~VS_POL;
               exp_q.push_back({m_hs, m_vs, m_rgb, m_vis, m_fs, 16'(m_fc)});
               mh++;
               if (mh == HT) begin
                  mh = 0;
                  mv++;
                  if (mv == VT) mv = 0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            check("sb_outputs",
                  {9'd0, vid.hsync, vid.vsync, vid.rgb, vid.visible, vid.frame_start, vid.frame_cnt},
                  {9'd0, sb_exp});
         end
      end
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic count_to(input int which, input logic lvl, input int limit, input string tag, output int n);
      logic s, hit;
      hit = 1'b0;
      n = 0;
      while (!hit && n < limit) begin
         @(negedge clock);
         n++;
         case (which)
            0:       s = vid.hsync;
            1:       s = vid.vsync;
            default: s = vid.frame_start;
         endcase
         hit = (s == lvl);
      end
      check({tag, "_seen"}, {31'd0, hit}, 32'd1);
   endtask

   task automatic scan_frame(input int k);
      int fr, fcol, outside;
      fr = -1; fcol = -1; outside = 0;
      for (int i = 0; i < FT; i++) begin
         if (vid.rgb != 3'b000) begin
            if ((i % HT) >= HV || (i / HT) >= VV) outside++;
            else if (fr < 0) begin
               fr   = i / HT;
               fcol = i % HT;
            end
         end
         @(negedge clock);
      end
      check("box_x", fcol, box_pos(k, HV - BOX));
      check("box_y", fr, box_pos(k, VV - BOX));
      check("box_blank_dark", outside, 0);
      check("box_next_fs", {31'd0, vid.frame_start}, 32'd1);
   endtask

   int n, t;

   initial begin
      step(3);
      check("rst_hsync", {31'd0, vid.hsync}, {31'd0, ~HS_POL});
      check("rst_vsync", {31'd0, vid.vsync}, {31'd0, ~VS_POL});
      check("rst_rgb", {29'd0, vid.rgb}, 32'd0);
      check("rst_visible", {31'd0, vid.visible}, 32'd0);
      check("rst_fs", {31'd0, vid.frame_start}, 32'd0);
      check("rst_fcnt", {16'd0, vid.frame_cnt}, 32'd0);

      // start up in bouncing-box mode and measure the raster timing of frame 1
      mode = 2'd3; enable = 1'b1; reset = 1'b0;
      count_to(2, 1'b1, 10, "fs_first", n);
      check("fs_latency", n, 2);
      check("fcnt_first", {16'd0, vid.frame_cnt}, 32'd1);
      t = 0;
      count_to(0, HS_POL, HT + 1, "hs_on", n);  t += n;
      check("hs_start", t, HV + HF);
      count_to(0, ~HS_POL, HT, "hs_off", n);    t += n;
      check("hs_width", n, HS);
      count_to(0, HS_POL, HT + 1, "hs_on2", n); t += n;
      check("line_period", t - (HV + HF), HT);
      count_to(1, VS_POL, FT, "vs_on", n);      t += n;
      check("vs_start", t, (VV + VF) * HT);
      count_to(1, ~VS_POL, FT, "vs_off", n);    t += n;
      check("vs_width", n, VS * HT);
      count_to(2, 1'b1, FT, "fs_second", n);    t += n;
      check("frame_period", t, FT);
      check("fcnt_second", {16'd0, vid.frame_cnt}, 32'd2);

      for (int k = 2; k <= 10; k++) scan_frame(k);

      // asynchronous reset in the middle of a line
      step(10);
      #2 reset = 1'b1; mode = 2'd0; solid_rgb = 3'd0;
      @(negedge clock);
      check("mrst_hsync", {31'd0, vid.hsync}, {31'd0, ~HS_POL});
      check("mrst_vsync", {31'd0, vid.vsync}, {31'd0, ~VS_POL});
      check("mrst_rgb", {29'd0, vid.rgb}, 32'd0);
      check("mrst_visible", {31'd0, vid.visible}, 32'd0);
      check("mrst_fs", {31'd0, vid.frame_start}, 32'd0);
      check("mrst_fcnt", {16'd0, vid.frame_cnt}, 32'd0);
      step(2);
      reset = 1'b0;
      count_to(2, 1'b1, 10, "fs_restart", n);
      check("fs_restart_lat", n, 2);
      check("fcnt_restart", {16'd0, vid.frame_cnt}, 32'd1);

      // colour bars on row 0
      check("bar_c0", {29'd0, vid.rgb}, 32'd7);
      step(7);  check("bar_c7", {29'd0, vid.rgb}, 32'd7);
      step(1);  check("bar_c8", {29'd0, vid.rgb}, 32'd6);
      step(16); check("bar_c24", {29'd0, vid.rgb}, 32'd4);
      step(39); check("bar_c63", {29'd0, vid.rgb}, 32'd0);
      step(1);  check("blank_rgb", {29'd0, vid.rgb}, 32'd0);
      check("blank_visible", {31'd0, vid.visible}, 32'd0);

      // mid-frame switch to solid colour only takes effect next frame
      step(20 * HT - 64);
      mode = 2'd2; solid_rgb = 3'b101;
      step(10 * HT);
      check("hold_bars", {29'd0, vid.rgb}, 32'd7);
      count_to(2, 1'b1, FT, "fs_solid", n);
      check("solid_c0", {29'd0, vid.rgb}, 32'd5);
      check("fcnt_solid", {16'd0, vid.frame_cnt}, 32'd2);
      step(39 * HT + 63);
      check("solid_end", {29'd0, vid.rgb}, 32'd5);

      // checkerboard
      mode = 2'd1;
      count_to(2, 1'b1, FT, "fs_check", n);
      check("fcnt_check", {16'd0, vid.frame_cnt}, 32'd3);
      check("ck_0_0", {29'd0, vid.rgb}, 32'd0);
      step(31);      check("ck_31_0", {29'd0, vid.rgb}, 32'd0);
      step(1);       check("ck_32_0", {29'd0, vid.rgb}, 32'd7);
      step(32 * HT); check("ck_32_32", {29'd0, vid.rgb}, 32'd0);

      // drop enable while hsync is active
      step(HV + HF + 1 - 32);
      check("hs_pre_drop", {31'd0, vid.hsync}, {31'd0, HS_POL});
      enable = 1'b0;
      @(negedge clock);
      check("drop_hsync", {31'd0, vid.hsync}, {31'd0, ~HS_POL});
      check("drop_visible", {31'd0, vid.visible}, 32'd0);
      check("drop_state", {31'd0, dbg_state}, 32'd0);
      check("drop_fcnt", {16'd0, vid.frame_cnt}, 32'd3);
      step(5);
      check("drop_fs", {31'd0, vid.frame_start}, 32'd0);
      enable = 1'b1;
      count_to(2, 1'b1, 10, "fs_reenable", n);
      check("fs_reenable_lat", n, 2);
      check("fcnt_reenable", {16'd0, vid.frame_cnt}, 32'd4);
      check("ck_re_0_0", {29'd0, vid.rgb}, 32'd0);
      step(32);
      check("ck_re_32_0", {29'd0, vid.rgb}, 32'd7);

      step(2);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
